iir_channel_scheduler: RTL and testbench

Shares one IIR filter engine between the left and right audio channels of the FM stereo path. Pulls samples from two channel input FIFOs in round-robin order and pushes them into the engine's input FIFO. Tracks the channel of every sample in flight, then steers each engine result to the matching left or right output FIFO. Sits between the stereo demux FIFOs and the de-emphasis output FIFOs, replacing a second filter instance.

---
 rtl/iir_channel_scheduler.sv | 127 ++++++++++++
 tb/tb_iir_channel_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_channel_scheduler.sv
// iir_channel_scheduler
// Time-shares one IIR engine between the left and right audio channels.
// Samples are pulled round-robin from the two input FIFOs and pushed into
// the engine. A small tag FIFO records the channel of every sample in flight
// so each engine result can be steered back to its own output FIFO, strictly
// in issue order. Sample data passes through untouched.

module iir_channel_scheduler #(
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           l_dout,
    input  logic                            l_empty,
    output logic                            l_rd_en,
    input  logic [DATA_WIDTH-1:0]           r_dout,
    input  logic                            r_empty,
    output logic                            r_rd_en,
    output logic [DATA_WIDTH-1:0]           eng_din,
    output logic                            eng_wr_en,
    input  logic                            eng_full,
    input  logic [DATA_WIDTH-1:0]           eng_dout,
    input  logic                            eng_empty,
    output logic                            eng_rd_en,
    output logic [DATA_WIDTH-1:0]           lo_din,
    output logic                            lo_wr_en,
    input  logic                            lo_full,
    output logic [DATA_WIDTH-1:0]           ro_din,
    output logic                            ro_wr_en,
    input  logic                            ro_full,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight,
    output logic                            tag_err
);

    localparam int PTR_W = $clog2(MAX_INFLIGHT);
    localparam logic [PTR_W:0] CREDITS = (PTR_W + 1)'(MAX_INFLIGHT);
    localparam logic [PTR_W:0] ONE     = (PTR_W + 1)'(1);

    // Round-robin preference: 0 = left preferred, 1 = right preferred
    logic             rr_ptr;
    // Tag FIFO pointers carry one extra wrap bit to tell full from empty
    logic [PTR_W:0]   tag_wr_ptr;
    logic [PTR_W:0]   tag_rd_ptr;
    // Channel of each in-flight sample: 0 = left, 1 = right
    logic             tag_mem [MAX_INFLIGHT];

    logic             can_issue;
    logic             grant_l;
    logic             grant_r;
    logic             issue;
    logic             tag_empty;
    logic             head_tag;
    logic             head_full;
    logic             retire;
    logic             orphan;

    // Issue arbitration and in-order retire steering, all same-cycle
    always_comb begin
        can_issue = 1'b0;
        grant_l   = 1'b0;
        grant_r   = 1'b0;
        issue     = 1'b0;
        tag_empty = (tag_wr_ptr == tag_rd_ptr);
        head_tag  = tag_mem[tag_rd_ptr[PTR_W-1:0]];
        head_full = head_tag ? ro_full : lo_full;
        retire    = 1'b0;
        orphan    = 1'b0;

        if (!reset) begin
            // Credit check uses the registered count only; a retire in the
            // same cycle does not free a slot until the next edge.
            can_issue = (inflight < CREDITS) && !eng_full;
            grant_l   = can_issue && !l_empty && (r_empty || !rr_ptr);
            grant_r   = can_issue && !r_empty && (l_empty ||  rr_ptr);
            issue     = grant_l || grant_r;
            // Head-of-line: a full output for the head tag stalls everything
            retire    = !eng_empty && !tag_empty && !head_full;
            orphan    = !eng_empty && tag_empty;
        end

        l_rd_en   = grant_l;
        r_rd_en   = grant_r;
        eng_wr_en = issue;
        eng_din   = grant_r ? r_dout : l_dout;
        eng_rd_en = retire;
        lo_wr_en  = retire && !head_tag;
        ro_wr_en  = retire &&  head_tag;
        lo_din    = eng_dout;
        ro_din    = eng_dout;
    end

    // Control state: arbitration pointer, credits, tag pointers, error flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr     <= 1'b0;
            inflight   <= '0;
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_err    <= 1'b0;
        end else begin
            if (issue) begin
                rr_ptr     <= grant_l;
                tag_wr_ptr <= tag_wr_ptr + ONE;
            end
            if (retire) begin
                tag_rd_ptr <= tag_rd_ptr + ONE;
            end
            if (issue && !retire) begin
                inflight <= inflight + ONE;
            end else if (!issue && retire) begin
                inflight <= inflight - ONE;
            end
            if (orphan) begin
                tag_err <= 1'b1;
            end
        end
    end

    // Tag storage: channel bit written at the issue slot, no reset needed
    always_ff @(posedge clock) begin
        if (issue) begin
            tag_mem[tag_wr_ptr[PTR_W-1:0]] <= grant_r;
        end
    end

endmodule

// File: tb/tb_iir_channel_scheduler.sv
// Testbench for iir_channel_scheduler: queue-based FIFO/engine environment
// plus a transaction-level scheduler model predicting every handshake.

module tb_iir_channel_scheduler;

    localparam int DW   = 32;
    localparam int MAXI = 4;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [DW-1:0]            l_dout, r_dout, eng_din, eng_dout, lo_din, ro_din;
    logic                     l_empty, l_rd_en, r_empty, r_rd_en;
    logic                     eng_wr_en, eng_full, eng_empty, eng_rd_en;
    logic                     lo_wr_en, lo_full, ro_wr_en, ro_full;
    logic [$clog2(MAXI):0]    inflight;
    logic                     tag_err;

    iir_channel_scheduler #(.DATA_WIDTH(DW), .MAX_INFLIGHT(MAXI)) dut (
        .clock(clock), .reset(reset),
        .l_dout(l_dout), .l_empty(l_empty), .l_rd_en(l_rd_en),
        .r_dout(r_dout), .r_empty(r_empty), .r_rd_en(r_rd_en),
        .eng_din(eng_din), .eng_wr_en(eng_wr_en), .eng_full(eng_full),
        .eng_dout(eng_dout), .eng_empty(eng_empty), .eng_rd_en(eng_rd_en),
        .lo_din(lo_din), .lo_wr_en(lo_wr_en), .lo_full(lo_full),
        .ro_din(ro_din), .ro_wr_en(ro_wr_en), .ro_full(ro_full),
        .inflight(inflight), .tag_err(tag_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] data;
        int            ready;
    } pipe_t;

    int            n_checks = 0;
    int            n_err    = 0;
    logic [DW-1:0] lq[$], rq[$], eo_q[$], lo_got[$], ro_got[$], issue_log[$];
    logic [DW-1:0] exp_l[$], exp_r[$];
    pipe_t         pipe_q[$];
    int            cyc      = 0;
    int            eng_lat  = 2;
    bit            hold     = 1'b0;
    bit            force_full = 1'b0;
    bit            lof      = 1'b0;
    bit            rof      = 1'b0;
    int            max_seen = 0;

    // scheduler reference model (transaction level)
    bit            m_rr       = 1'b0;
    int            m_inflight = 0;
    bit            m_tags[$];
    bit            m_tag_err  = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive();
        l_empty   = (lq.size() == 0);
        l_dout    = l_empty ? '0 : lq[0];
        r_empty   = (rq.size() == 0);
        r_dout    = r_empty ? '0 : rq[0];
        eng_empty = hold || (eo_q.size() == 0);
        eng_dout  = (eo_q.size() == 0) ? '0 : eo_q[0];
        eng_full  = force_full;
        lo_full   = lof;
        ro_full   = rof;
    endtask

    task automatic step();
        bit ln, rn, can, el, er, ev, hd, hf, eret, te;
        logic o_l, o_r, o_w, o_rd, o_lw, o_rw;
        logic [DW-1:0] o_din, o_lod, o_rod;
        @(negedge clock);
        ln   = (lq.size() > 0);
        rn   = (rq.size() > 0);
        can  = (m_inflight < MAXI) && !force_full;
        el   = can && ln && (!rn || !m_rr);
        er   = can && rn && (!ln ||  m_rr);
        ev   = !hold && (eo_q.size() > 0);
        te   = (m_tags.size() == 0);
        hd   = te ? 1'b0 : m_tags[0];
        hf   = hd ? rof : lof;
        eret = ev && !te && !hf;
        check1("l_rd_en", l_rd_en, el);
        check1("r_rd_en", r_rd_en, er);
        check1("eng_wr_en", eng_wr_en, el | er);
        if (el) check("eng_din_l", eng_din, lq[0]);
        if (er) check("eng_din_r", eng_din, rq[0]);
        check1("eng_rd_en", eng_rd_en, eret);
        check1("lo_wr_en", lo_wr_en, eret && !hd);
        check1("ro_wr_en", ro_wr_en, eret && hd);
        if (eo_q.size() > 0) begin
            check("lo_din", lo_din, eo_q[0]);
            check("ro_din", ro_din, eo_q[0]);
        end
        check("inflight", 32'(inflight), 32'(m_inflight));
        check1("tag_err", tag_err, m_tag_err);
        if (int'(inflight) > max_seen) max_seen = int'(inflight);
        o_l = l_rd_en; o_r = r_rd_en; o_w = eng_wr_en; o_din = eng_din;
        o_rd = eng_rd_en; o_lw = lo_wr_en; o_rw = ro_wr_en; o_lod = lo_din; o_rod = ro_din;
        @(posedge clock);
        #1;
        // environment follows what the DUT actually did
        if (o_l === 1'b1 && lq.size() > 0) void'(lq.pop_front());
        if (o_r === 1'b1 && rq.size() > 0) void'(rq.pop_front());
        if (o_w === 1'b1) begin
            pipe_q.push_back('{data: o_din, ready: cyc + eng_lat});
            issue_log.push_back(o_din);
        end
        if (o_rd === 1'b1 && eo_q.size() > 0) void'(eo_q.pop_front());
        if (o_lw === 1'b1) lo_got.push_back(o_lod);
        if (o_rw === 1'b1) ro_got.push_back(o_rod);
        // model follows the rules
        if (el || er) begin
            m_tags.push_back(er);
            m_rr = el;
        end
        if (eret) void'(m_tags.pop_front());
        m_inflight = m_inflight + int'(el || er) - int'(eret);
        if (ev && te) m_tag_err = 1'b1;
        cyc++;
        while (pipe_q.size() > 0 && pipe_q[0].ready <= cyc) eo_q.push_back(pipe_q.pop_front().data);
        drive();
    endtask

    function automatic bit busy();
        return (lq.size() > 0) || (rq.size() > 0) || (pipe_q.size() > 0) ||
               (eo_q.size() > 0) || (m_tags.size() > 0);
    endfunction

    task automatic drain(input int budget);
        int k = 0;
        while (busy() && k < budget) begin
            step();
            k++;
        end
        check1("drain_idle", busy(), 1'b0);
    endtask

    task automatic clear_got();
        lo_got.delete(); ro_got.delete(); issue_log.delete();
        exp_l.delete(); exp_r.delete();
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_lo_count"}, 32'(lo_got.size()), 32'(exp_l.size()));
        check({tag, "_ro_count"}, 32'(ro_got.size()), 32'(exp_r.size()));
        if (lo_got.size() == exp_l.size())
            foreach (exp_l[i]) check({tag, "_lo_data"}, lo_got[i], exp_l[i]);
        if (ro_got.size() == exp_r.size())
            foreach (exp_r[i]) check({tag, "_ro_data"}, ro_got[i], exp_r[i]);
    endtask

    initial begin
        logic [DW-1:0] v;
        // reset state, with input samples present to show enables are forced low
        reset = 1'b1;
        lq.push_back(32'd7); rq.push_back(32'd8);
        drive();
        #3;
        check1("rst_l_rd_en", l_rd_en, 1'b0);
        check1("rst_r_rd_en", r_rd_en, 1'b0);
        check1("rst_eng_wr_en", eng_wr_en, 1'b0);
        check("rst_inflight", 32'(inflight), 32'd0);
        check1("rst_tag_err", tag_err, 1'b0);
        lq.delete(); rq.delete();
        drive();
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;

        // alternating fairness
        clear_got(); max_seen = 0;
        for (int i = 1; i <= 8; i++) begin
            lq.push_back(32'(i));       exp_l.push_back(32'(i));
            rq.push_back(32'(100 + i)); exp_r.push_back(32'(100 + i));
        end
        drive();
        drain(100);
        check("alt_issue_count", 32'(issue_log.size()), 32'd16);
        if (issue_log.size() == 16)
            for (int i = 0; i < 16; i++)
                check("alt_issue_order", issue_log[i], (i % 2 == 0) ? 32'(i / 2 + 1) : 32'(101 + i / 2));
        check_outputs("alt");
        check1("alt_max_inflight", max_seen <= MAXI, 1'b1);

        // single channel: right only
        clear_got();
        for (int i = 5; i <= 7; i++) begin
            rq.push_back(32'(i)); exp_r.push_back(32'(i));
        end
        drive();
        repeat (3) step();
        check("single_rq_left", 32'(rq.size()), 32'd0);
        drain(50);
        check_outputs("single");

        // credit limit
        clear_got();
        hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lq.push_back(32'(201 + i)); exp_l.push_back(32'(201 + i));
        end
        drive();
        repeat (8) step();
        check("credit_lq_left", 32'(lq.size()), 32'd2);
        check("credit_inflight", 32'(inflight), 32'd4);
        check1("credit_l_rd_en", l_rd_en, 1'b0);
        hold = 1'b0; drive();
        step();
        hold = 1'b1; drive();
        step();
        step();
        check("credit_one_more", 32'(lq.size()), 32'd1);
        check("credit_inflight2", 32'(inflight), 32'd4);
        hold = 1'b0; drive();
        drain(100);
        check_outputs("credit");

        // head-of-line blocking
        clear_got();
        lof = 1'b1;
        lq.push_back(32'd11); exp_l.push_back(32'd11);
        drive(); step();
        rq.push_back(32'd111); exp_r.push_back(32'd111);
        drive(); step();
        repeat (5) step();
        check1("hol_eng_rd_en", eng_rd_en, 1'b0);
        check("hol_inflight", 32'(inflight), 32'd2);
        check("hol_waiting", 32'(eo_q.size()), 32'd2);
        lof = 1'b0; drive();
        step();
        check("hol_lo_first", 32'(lo_got.size()), 32'd1);
        check("hol_ro_wait", 32'(ro_got.size()), 32'd0);
        step();
        check("hol_ro_next", 32'(ro_got.size()), 32'd1);
        drain(50);
        check_outputs("hol");

        // simultaneous issue/retire at inflight=3 across pointer wrap
        clear_got();
        eng_lat = 3;
        for (int i = 0; i < 10; i++) begin
            v = $urandom; lq.push_back(v); exp_l.push_back(v);
            v = $urandom; rq.push_back(v); exp_r.push_back(v);
        end
        drive();
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k >= 4) check("steady_inflight", 32'(inflight), 32'd3);
        end
        drain(100);
        check_outputs("steady");
        eng_lat = 2;

        // randomized traffic with backpressure everywhere
        clear_got();
        for (int k = 0; k < 400; k++) begin
            if (lq.size() < 8 && $urandom_range(0, 1) == 1) begin
                v = $urandom; lq.push_back(v); exp_l.push_back(v);
            end
            if (rq.size() < 8 && $urandom_range(0, 2) != 0) begin
                v = $urandom; rq.push_back(v); exp_r.push_back(v);
            end
            force_full = ($urandom_range(0, 3) == 0);
            lof        = ($urandom_range(0, 2) == 0);
            rof        = ($urandom_range(0, 2) == 0);
            hold       = ($urandom_range(0, 4) == 0);
            drive();
            step();
        end
        force_full = 1'b0; lof = 1'b0; rof = 1'b0; hold = 1'b0;
        drive();
        drain(300);
        check_outputs("rand");

        // orphan engine result sets sticky tag_err
        eo_q.push_back(32'hDEAD_BEEF);
        drive();
        step();
        check1("err_set", tag_err, 1'b1);
        repeat (3) step();
        check1("err_sticky", tag_err, 1'b1);

        // reset mid-stream with two samples in flight
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lq.push_back(32'(301 + i)); rq.push_back(32'(401 + i));
        end
        drive();
        step(); step();
        check("mid_inflight", 32'(inflight), 32'd2);
        hold = 1'b0; drive();
        reset = 1'b1;
        #1;
        check1("mid_l_rd_en", l_rd_en, 1'b0);
        check1("mid_r_rd_en", r_rd_en, 1'b0);
        check1("mid_eng_wr_en", eng_wr_en, 1'b0);
        check1("mid_eng_rd_en", eng_rd_en, 1'b0);
        check1("mid_lo_wr_en", lo_wr_en, 1'b0);
        check1("mid_ro_wr_en", ro_wr_en, 1'b0);
        check("mid_rst_inflight", 32'(inflight), 32'd0);
        check1("mid_rst_tag_err", tag_err, 1'b0);
        // every FIFO and the engine share this reset
        m_rr = 1'b0; m_inflight = 0; m_tags.delete(); m_tag_err = 1'b0;
        lq.delete(); rq.delete(); pipe_q.delete(); eo_q.delete();
        clear_got();
        drive();
        @(posedge clock); #1;
        reset = 1'b0;
        lq.push_back(32'd501); exp_l.push_back(32'd501);
        rq.push_back(32'd601); exp_r.push_back(32'd601);
        drive();
        #1;
        check1("post_rst_left_first", l_rd_en, 1'b1);
        step();
        drain(50);
        check_outputs("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
